// File: rtl/ysyx_22050243_defs.sv
// Shared definitions for the ysyx_22050243 fetch path.
// Holds stall bus bit positions, bus widths, the NOP encoding, the reset PC,
// and the layout of one fetch-queue entry (pc + instruction word).
package ysyx_22050243_defs;

  // Stall bus bit positions
  localparam int STALL_EX   = 0;
  localparam int STALL_LOAD = 1;
  localparam int STALL_ID   = 2;
  localparam int STALL_RSVD = 3;

  localparam int IF_2_ID_W = 129;
  localparam int ID_BUS_W  = 97;

  localparam logic [31:0] INST_NOP = 32'h0000_0013;
  localparam logic [63:0] RESET_PC = 64'h7fff_fffc;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;

  localparam int IFQ_ENTRY_W = $bits(ifq_entry_t);

endpackage

// File: rtl/ysyx_22050243_fifo2.sv
// Generic 2-entry synchronous FIFO.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   i_push/i_wdata: write request and data
//   i_pop         : consume head entry
//   i_clear       : empty the FIFO; wins over push and pop
//   o_full/o_empty: occupancy flags
//   o_head        : head entry contents (undefined when empty)
// A push while full is accepted only if a pop happens in the same cycle;
// otherwise it is dropped and the caller is expected to flag it.
module ysyx_22050243_fifo2 #(
  parameter int W = 96
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  input  logic         i_clear,
  output logic         o_full,
  output logic         o_empty,
  output logic [W-1:0] o_head
);

  logic [W-1:0] r_mem [2];
  logic         r_wp;
  logic         r_rp;
  logic [1:0]   r_cnt;
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_cnt == 2'd0);
  assign o_full    = (r_cnt == 2'd2);
  assign w_do_pop  = i_pop & ~o_empty;
  // When full, wp == rp, so a simultaneous push overwrites the slot being popped.
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rp];

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_wp  <= 1'b0;
      r_rp  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (w_do_push) r_wp <= ~r_wp;
      if (w_do_pop)  r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, w_do_push} - {1'b0, w_do_pop};
    end
  end

  // Storage needs no reset: contents are only observed when non-empty.
  always_ff @(posedge clk) begin
    if (!rst && !i_clear && w_do_push) r_mem[r_wp] <= i_wdata;
  end

endmodule

// File: rtl/ysyx_22050243_ifq.sv
// Instruction fetch queue between IF and ID.
// Pairs each fetch address issued to the synchronous instruction SRAM with the
// word returned one cycle later, buffers pairs in a 2-entry queue and presents
// {valid, pc, inst} to ID. A branch redirect discards all wrong-path fetches.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   if_2_id_bus  : {ce, if_pc[63:0], next_pc[63:0]} from IF
//   isram_rdata  : SRAM data for the address presented last cycle
//   stall        : stall bus (bit0 ex, bit1 load, bit2 id, bit3 reserved)
//   br_e         : branch redirect from EX
//   id_2_bus     : {id_valid, id_pc[63:0], id_inst[31:0]} to ID
//   ifq_ovf      : sticky overflow flag (queue full, push without pop)
module ysyx_22050243_ifq
  import ysyx_22050243_defs::*;
#(
  parameter int          DEPTH = 2,
  parameter logic [31:0] NOP   = INST_NOP
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IF_2_ID_W-1:0] if_2_id_bus,
  input  logic [31:0]          isram_rdata,
  input  logic [5:0]           stall,
  input  logic                 br_e,
  output logic [ID_BUS_W-1:0]  id_2_bus,
  output logic                 ifq_ovf
);

  localparam int unused_depth = DEPTH;

  logic        w_ce;
  logic [63:0] w_if_pc;
  logic [63:0] w_next_pc;
  logic        w_fstall;
  logic        w_dhold;
  logic        w_issue;
  logic        w_push;
  logic        w_pop;
  logic        w_full;
  logic        w_empty;
  ifq_entry_t  w_head;
  ifq_entry_t  w_wdata;
  logic        w_unused_bits;

  logic        r_req_v;
  logic [63:0] r_req_pc;
  logic        r_ovf;

  assign {w_ce, w_if_pc, w_next_pc} = if_2_id_bus;
  assign w_unused_bits = &{1'b0, w_next_pc, stall[5:4]};

  // fstall mirrors the condition under which IF holds its pc.
  assign w_fstall = stall[STALL_EX] | stall[STALL_LOAD] | stall[STALL_RSVD];
  assign w_dhold  = w_fstall | stall[STALL_ID];

  // A held pc is recorded only in the cycle it advances; pc 0 marks a bubble.
  assign w_issue = w_ce & ~w_fstall & (w_if_pc != 64'd0);

  // br_e kills the response landing this cycle and blocks consumption.
  assign w_push  = r_req_v & ~br_e;
  assign w_pop   = ~w_empty & ~w_dhold & ~br_e;
  assign w_wdata = '{pc: r_req_pc, inst: isram_rdata};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_req_v  <= 1'b0;
      r_req_pc <= 64'd0;
    end else begin
      r_req_v <= w_issue & ~br_e;
      if (w_issue && !br_e) r_req_pc <= w_if_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_ovf <= 1'b0;
    else if (w_push && w_full && !w_pop) r_ovf <= 1'b1;
  end

  ysyx_22050243_fifo2 #(.W(IFQ_ENTRY_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_wdata (w_wdata),
    .i_pop   (w_pop),
    .i_clear (br_e),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

  assign id_2_bus = {~w_empty,
                     w_empty ? 64'd0 : w_head.pc,
                     w_empty ? NOP   : w_head.inst};
  assign ifq_ovf  = r_ovf;

endmodule

// File: tb/tb_ysyx_22050243_ifq.sv
module tb_ysyx_22050243_ifq;

  logic        clk = 1'b0;
  logic        rst;
  logic        ce;
  logic [63:0] if_pc;
  logic [31:0] rdata;
  logic [5:0]  stall;
  logic        br_e;
  logic [128:0] bus;
  logic [96:0]  id_bus;
  logic         ovf;

  int total = 0;
  int bad   = 0;

  // reference model state
  logic [95:0] exp_q[$];
  logic        m_req_v  = 1'b0;
  logic [63:0] m_req_pc = 64'd0;
  logic        m_ovf    = 1'b0;

  assign bus = {ce, if_pc, if_pc + 64'd4};

  always #5 clk = ~clk;

  ysyx_22050243_ifq dut (
    .clk         (clk),
    .rst         (rst),
    .if_2_id_bus (bus),
    .isram_rdata (rdata),
    .stall       (stall),
    .br_e        (br_e),
    .id_2_bus    (id_bus),
    .ifq_ovf     (ovf)
  );

  function automatic logic [97:0] exp_bus();
    if (exp_q.size() == 0) return {m_ovf, 1'b0, 64'd0, 32'h0000_0013};
    return {m_ovf, 1'b1, exp_q[0]};
  endfunction

  // Drive one cycle of inputs, advance the model at the edge, settle #1 after it.
  task automatic cyc(input logic c, input logic [63:0] p, input logic [31:0] d,
                     input logic [5:0] s, input logic b);
    bit fst, dh, popping, pushing;
    ce = c; if_pc = p; rdata = d; stall = s; br_e = b;
    @(posedge clk);
    if (rst) begin
      exp_q.delete();
      m_req_v = 1'b0; m_req_pc = 64'd0; m_ovf = 1'b0;
    end else begin
      fst = s[0] | s[1] | s[3];
      dh  = fst | s[2];
      popping = (exp_q.size() != 0) && !dh && !b;
      pushing = m_req_v && !b;
      if (b) exp_q.delete();
      else begin
        if (popping) void'(exp_q.pop_front());
        if (pushing) begin
          if (exp_q.size() < 2) exp_q.push_back({m_req_pc, d});
          else m_ovf = 1'b1;
        end
      end
      m_req_v = !b && c && !fst && (p != 64'd0);
      if (m_req_v) m_req_pc = p;
    end
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    cyc(1'b1, 64'h8000_0000, 32'h1234_5678, 6'd0, 1'b0);
    cyc(1'b0, 64'd0, 32'd0, 6'd0, 1'b0);
    rst = 1'b0;
    total++; if (id_bus[96] !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", id_bus[96]); end
    total++; if (id_bus[95:32] !== 64'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", id_bus[95:32]); end
    total++; if (id_bus[31:0] !== 32'h0000_0013) begin bad++; $display("FAIL reset_inst got=%h exp=00000013", id_bus[31:0]); end
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
  endtask

  task automatic test_stream();
    logic [63:0] pcs [6];
    logic        cs  [6];
    logic [31:0] ds  [6];
    logic [96:0] want[6];
    pcs  = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'd0, 64'd0, 64'd0};
    cs   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ds   = '{32'hdead_beef, 32'h0010_0093, 32'h0020_0113, 32'h0030_0193, 32'hcafe_f00d, 32'h0bad_0bad};
    want = '{{1'b0, 64'd0, 32'h13},
             {1'b1, 64'h8000_0000, 32'h0010_0093},
             {1'b1, 64'h8000_0004, 32'h0020_0113},
             {1'b1, 64'h8000_0008, 32'h0030_0193},
             {1'b0, 64'd0, 32'h13},
             {1'b0, 64'd0, 32'h13}};
    for (int k = 0; k < 6; k++) begin
      cyc(cs[k], pcs[k], ds[k], 6'd0, 1'b0);
      total++; if (id_bus !== want[k]) begin bad++; $display("FAIL stream_fixed k=%0d got=%h exp=%h", k, id_bus, want[k]); end
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL stream_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
    end
  endtask

  task automatic test_id_stall();
    logic [63:0] pcs [11];
    logic        cs  [11];
    logic [5:0]  st  [11];
    logic [31:0] ds  [11];
    logic [63:0] want[4];
    logic [63:0] seen[$];
    pcs = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000c, 64'h8000_000c,
            64'h8000_000c, 64'h8000_000c, 64'd0, 64'd0, 64'd0, 64'd0};
    cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    st  = '{6'd0, 6'd0, 6'd0, 6'b000010, 6'b000010, 6'b000010, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    want = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000c};
    for (int i = 0; i < 11; i++) ds[i] = $urandom;
    for (int k = 0; k < 11; k++) begin
      if (id_bus[96] && st[k][3:0] == 4'd0) seen.push_back(id_bus[95:32]);
      cyc(cs[k], pcs[k], ds[k], st[k], 1'b0);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL stall_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
      if (k >= 3 && k <= 5) begin
        total++;
        if (id_bus[96] !== 1'b1 || id_bus[95:32] !== 64'h8000_0004 || ovf !== 1'b0) begin
          bad++; $display("FAIL stall_frozen k=%0d got_pc=%h got_ovf=%b exp_pc=80000004 exp_ovf=0", k, id_bus[95:32], ovf);
        end
      end
    end
    total++;
    if (seen.size() != 4) begin
      bad++; $display("FAIL stall_consumed_count got=%0d exp=4", seen.size());
    end else begin
      for (int i = 0; i < 4; i++)
        if (seen[i] !== want[i]) begin bad++; $display("FAIL stall_order i=%0d got=%h exp=%h", i, seen[i], want[i]); end
    end
  endtask

  task automatic test_flush();
    logic [63:0] pcs [8];
    logic        cs  [8];
    logic [5:0]  st  [8];
    logic        bs  [8];
    logic [31:0] ds  [8];
    pcs = '{64'h8000_0000, 64'h8000_0004, 64'h8000_0008, 64'h8000_000c,
            64'h8000_0100, 64'h8000_0104, 64'd0, 64'd0};
    cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    st  = '{6'd0, 6'd0, 6'b000100, 6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    bs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 8; i++) ds[i] = $urandom;
    for (int k = 0; k < 8; k++) begin
      cyc(cs[k], pcs[k], ds[k], st[k], bs[k]);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL flush_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
      if (k == 3 || k == 4) begin
        total++; if (id_bus[96] !== 1'b0) begin bad++; $display("FAIL flush_valid k=%0d got=%b exp=0", k, id_bus[96]); end
      end
      if (k == 5) begin
        total++;
        if (id_bus !== {1'b1, 64'h8000_0100, ds[5]}) begin
          bad++; $display("FAIL flush_target got=%h exp=%h", id_bus, {1'b1, 64'h8000_0100, ds[5]});
        end
      end
    end
  endtask

  task automatic test_flush_priority();
    logic [63:0] pcs [6];
    logic        cs  [6];
    logic        bs  [6];
    logic [31:0] ds  [6];
    pcs = '{64'h8000_0200, 64'h8000_0204, 64'h8000_0208, 64'h8000_0300, 64'd0, 64'd0};
    cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    bs  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) ds[i] = $urandom;
    for (int k = 0; k < 6; k++) begin
      cyc(cs[k], pcs[k], ds[k], 6'd0, bs[k]);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL prio_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
      if (k == 2 || k == 3) begin
        total++; if (id_bus[96] !== 1'b0) begin bad++; $display("FAIL prio_empty k=%0d got=%b exp=0", k, id_bus[96]); end
      end
      if (k == 4) begin
        total++; if (id_bus[95:32] !== 64'h8000_0300) begin bad++; $display("FAIL prio_next got=%h exp=80000300", id_bus[95:32]); end
      end
    end
  endtask

  task automatic test_overflow();
    logic [63:0] pcs [10];
    logic        cs  [10];
    logic [5:0]  st  [10];
    logic        bs  [10];
    logic [31:0] ds  [10];
    pcs = '{64'h8000_0400, 64'h8000_0404, 64'h8000_0408, 64'h8000_040c,
            64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0};
    cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    st  = '{6'b000100, 6'b000100, 6'b000100, 6'b000100, 6'b000100,
            6'd0, 6'd0, 6'd0, 6'd0, 6'd0};
    bs  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) ds[i] = $urandom;
    for (int k = 0; k < 10; k++) begin
      cyc(cs[k], pcs[k], ds[k], st[k], bs[k]);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL ovf_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
      if (k == 2) begin
        total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_early got=%b exp=0", ovf); end
      end
      if (k == 4) begin
        total++;
        if ({ovf, id_bus} !== {1'b1, 1'b1, 64'h8000_0400, ds[1]}) begin
          bad++; $display("FAIL ovf_head0 got=%h exp=%h", {ovf, id_bus}, {1'b1, 1'b1, 64'h8000_0400, ds[1]});
        end
      end
      if (k == 5) begin
        total++;
        if (id_bus !== {1'b1, 64'h8000_0404, ds[2]}) begin
          bad++; $display("FAIL ovf_head1 got=%h exp=%h", id_bus, {1'b1, 64'h8000_0404, ds[2]});
        end
      end
      if (k == 6 || k == 9) begin
        total++;
        if (id_bus[96] !== 1'b0 || ovf !== 1'b1) begin
          bad++; $display("FAIL ovf_sticky k=%0d got_valid=%b got_ovf=%b exp_valid=0 exp_ovf=1", k, id_bus[96], ovf);
        end
      end
    end
    rst = 1'b1;
    cyc(1'b0, 64'd0, 32'd0, 6'd0, 1'b0);
    rst = 1'b0;
    total++; if (ovf !== 1'b0) begin bad++; $display("FAIL ovf_cleared got=%b exp=0", ovf); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] pcs [6];
    logic        cs  [6];
    logic [5:0]  st  [6];
    logic        rs  [6];
    logic [31:0] ds  [6];
    pcs = '{64'h8000_0500, 64'h8000_0504, 64'h8000_0508, 64'h8000_050c, 64'd0, 64'd0};
    cs  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    st  = '{6'd0, 6'd0, 6'b000100, 6'd0, 6'd0, 6'd0};
    rs  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) ds[i] = $urandom;
    for (int k = 0; k < 6; k++) begin
      rst = rs[k];
      cyc(cs[k], pcs[k], ds[k], st[k], 1'b0);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL rstmid_model k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
      if (k >= 3) begin
        total++;
        if (id_bus !== {1'b0, 64'd0, 32'h0000_0013}) begin
          bad++; $display("FAIL rstmid_empty k=%0d got=%h exp=%h", k, id_bus, {1'b0, 64'd0, 32'h0000_0013});
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    logic        c, b;
    logic [63:0] p;
    logic [5:0]  s;
    int          r;
    for (int k = 0; k < 600; k++) begin
      c = ($urandom_range(0, 3) != 0);
      p = ($urandom_range(0, 15) == 0) ? 64'd0 : {32'h8000_0000 | 32'($urandom_range(0, 4095)), $urandom} & ~64'd3;
      r = $urandom_range(0, 9);
      case (r)
        6: s = 6'b000001;
        7: s = 6'b000010;
        8: s = 6'b000100;
        9: s = 6'($urandom);
        default: s = 6'd0;
      endcase
      b   = ($urandom_range(0, 19) == 0);
      rst = ($urandom_range(0, 99) == 0);
      cyc(c, p, $urandom, s, b);
      total++; if ({ovf, id_bus} !== exp_bus()) begin bad++; $display("FAIL random k=%0d got=%h exp=%h", k, {ovf, id_bus}, exp_bus()); end
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; ce = 1'b0; if_pc = 64'd0; rdata = 32'd0; stall = 6'd0; br_e = 1'b0;
    test_reset();
    test_stream();
    test_id_stall();
    test_flush();
    test_flush_priority();
    test_overflow();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050243_ifq.md
# ysyx_22050243_ifq

Instruction fetch queue between the IF stage and ID. Pairs each fetch address that IF issues to the synchronous instruction SRAM with the instruction word returned one cycle later. Buffers pairs in a 2-entry queue so ID stalls never lose a fetch, and discards wrong-path fetches when a branch redirect occurs. Presents a registered `{valid, pc, inst}` bundle to ID.

## Interface
- `DEPTH`, 2: queue entries. Only 2 is supported.
- `NOP`, 32'h0000_0013: value driven on `id_inst` when not valid.
- `clk` in 1: clock. One clock domain.
- `rst` in 1: reset, synchronous, active-high.
- `if_2_id_bus` in 129: `{ce, if_pc[63:0], next_pc[63:0]}` from IF.
- `isram_rdata` in 32: SRAM read data for the address presented in the previous cycle.
- `stall` in 6: stall bus.
  - bit0 ex_stall, bit1 load_stall, bit2 id_stall, bit3 reserved, bits 5:4 unused.
- `br_e` in 1: branch redirect from EX (bit 64 of `br_bus`).
- `id_2_bus` out 97: `{id_valid, id_pc[63:0], id_inst[31:0]}`.
- `ifq_ovf` out 1: sticky overflow error flag.

## Operation
- `fstall = stall[0] | stall[1] | stall[3]`. This matches the IF hold condition.
- `dhold = fstall | stall[2]`.
- Issue:
  - `issue = ce & ~fstall & (if_pc != 0)`.
  - On issue, register `req_v <= 1` and `req_pc <= if_pc`. Otherwise `req_v <= 0`.
  - A fetch whose pc is held by a stall is therefore recorded once, in its advancing cycle.
- Response: in the cycle after an issue (`req_v = 1`), push `{req_pc, isram_rdata}` into the queue, unless killed.
- Kill: `br_e` in cycle N has these effects:
  - Sets `req_v <= 0`. The request issued in cycle N is wrong-path.
  - Suppresses the push of the response arriving in cycle N.
  - Clears all queue entries.
- Pop: the head entry is consumed when `id_valid & ~dhold & ~br_e`.
- Output:
  - `id_valid` = queue non-empty.
  - `id_pc` / `id_inst` come from the head entry's flops.
  - When empty, `id_pc = 0` and `id_inst = NOP`.
- Simultaneous push and pop: both happen. Count is unchanged and order is preserved.
- Push when count = 2 and no pop: entry dropped, `ifq_ovf <= 1`. The flag is sticky until `rst`. This is unreachable under correct stall protocol.
- Flush priority: `br_e` overrides push, pop and issue in the same cycle.

## Timing
- Reset values:
  - queue empty, `id_valid = 0`, `id_pc = 0`, `id_inst = NOP`
  - `req_v = 0`, `req_pc = 0`
  - `ifq_ovf = 0`
- `rst` mid-operation discards all in-flight and queued fetches on the next edge.
- Latency: issue at cycle N, SRAM data at N+1, `id_valid` with that pc at N+2. There is no combinational bypass.
- Throughput: one instruction per cycle sustained when no stalls.
- Flush at N:
  - `id_valid = 0` at N+1.
  - The first redirect-target fetch is issued at N+1 and seen by ID at N+3.
- Occupancy:
  - While `fstall` holds, IF stops issuing. At most one in-flight response lands, so the count is ≤ 2.
  - With `stall[2]` alone, IF keeps issuing. The queue can fill to 2; on the next push with no pop, `ifq_ovf` sets. `stall[2]` must be paired with `fstall` by the stall controller.
- Queue pointers are 1-bit and wrap modulo 2. Count is 2 bits, range 0..2.

## Structure
- Shared package `ysyx_22050243_defs` holds:
  - stall bit indices
  - `IF_2_ID_W = 129`, `ID_BUS_W = 97`
  - `INST_NOP`
  - reset PC `64'h7fff_fffc`
- One sub-module: `ysyx_22050243_fifo2`.
  - Generic 2-entry synchronous FIFO with parameter `W` (96 here).
  - Ports: push, pop, clear, full, empty, head.
  - Clear has priority over push and pop.
- Top level holds the request register, kill logic, output muxing and the overflow flag.

## Test plan
- Reset then stream:
  - IF issues 0x8000_0000, 0x8000_0004, 0x8000_0008 in consecutive cycles; SRAM returns 0x00100093, 0x00200113, 0x00300193.
  - Expect `id_valid` from cycle 3 of the stream, pcs in order, matching insts, one per cycle.
- ID stall:
  - Assert `stall[1]` for 3 cycles mid-stream.
  - Expect queue count 2, `id_pc` frozen at 0x8000_0004, no duplicate and no loss after release, `ifq_ovf = 0`.
- Branch flush:
  - With 2 entries queued and one in flight, pulse `br_e`; IF redirects to 0x8000_0100.
  - Expect `id_valid = 0` next cycle. The next valid pc is 0x8000_0100, exactly 3 cycles after `br_e`.
- Flush priority:
  - `br_e` in the same cycle as a pop and a push.
  - Expect queue empty and the popped entry counted as not consumed.
- Overflow:
  - Hold `stall[2]` only while IF streams 4 fetches.
  - Expect `ifq_ovf = 1`, sticky until `rst`, and the first 2 entries intact.
- Reset mid-operation:
  - Assert `rst` with 2 entries queued and one in flight.
  - Expect empty, `id_inst = 0x00000013`, and no stale push on the cycle after `rst` deasserts.
